// File: rtl/turfbus_phy.sv
// turfbus_phy: SURF-side serial PHY for the TURFbus link.
// Deserializes active-low TREQ request frames (W flag, 20-bit address,
// optional 32-bit write data) into a one-entry command holding register,
// and serializes bridge read data back onto the active-low SREQ line.
// Optional build macro: TURFBUS_PARITY_EN adds an even-parity bit to both
// directions and the perr_o output.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. The command side holds cmd_we_o/cmd_adr_o/cmd_dat_o stable
// while cmd_valid_o is high; the response side captures rsp_dat_i when
// rsp_valid_i is high while rsp_ready_o is high.
module turfbus_phy (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        treq_neg_i,
    output logic        sreq_neg_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        cmd_we_o,
    output logic [19:0] cmd_adr_o,
    output logic [31:0] cmd_dat_o,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    input  logic [31:0] rsp_dat_i,
`ifdef TURFBUS_PARITY_EN
    output logic        perr_o,
`endif
    output logic        drop_o
);

    typedef enum logic [2:0] {
        RX_ARM,
        RX_IDLE,
        RX_WBIT,
        RX_ADDR,
        RX_DATA
`ifdef TURFBUS_PARITY_EN
        , RX_PAR
`endif
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_SHIFT
`ifdef TURFBUS_PARITY_EN
        , TX_TPAR
`endif
    } tx_state_t;

    // Line bit: the request line is active-low.
    logic        line_bit;
    assign line_bit = ~treq_neg_i;

    // Receive deserializer state.
    rx_state_t   rx_q, rx_d;
    logic [5:0]  rcnt_q, rcnt_d;
    logic        we_sr_q, we_sr_d;
    logic [19:0] adr_sr_q, adr_sr_d;
    logic [31:0] dat_sr_q, dat_sr_d;
    logic [31:0] fr_dat;
    logic        frame_done;
`ifdef TURFBUS_PARITY_EN
    logic        frame_bad;
    logic        par_calc;
`endif

    // Command holding register (single skid entry).
    logic        cmd_valid_q, cmd_valid_d;
    logic        cmd_we_q, cmd_we_d;
    logic [19:0] cmd_adr_q, cmd_adr_d;
    logic [31:0] cmd_dat_q, cmd_dat_d;
    logic        drop_q, drop_d;
    logic        cmd_hs, cmd_load;
`ifdef TURFBUS_PARITY_EN
    logic        perr_q, perr_d;
`endif

    // Transmit serializer state.
    tx_state_t   tx_q, tx_d;
    logic [5:0]  tcnt_q, tcnt_d;
    logic [31:0] tsr_q, tsr_d;
    logic        sreq_q, sreq_d;
    logic [4:0]  tidx;

    // Read frames carry no data; force the data field to zero for them.
    assign fr_dat = we_sr_q ? dat_sr_d : 32'h0;
`ifdef TURFBUS_PARITY_EN
    assign par_calc = ^{we_sr_q, adr_sr_q, fr_dat};
`endif

    // Receive FSM: next state, shift registers and frame completion.
    always_comb begin
        rx_d       = rx_q;
        rcnt_d     = rcnt_q;
        we_sr_d    = we_sr_q;
        adr_sr_d   = adr_sr_q;
        dat_sr_d   = dat_sr_q;
        frame_done = 1'b0;
`ifdef TURFBUS_PARITY_EN
        frame_bad  = 1'b0;
`endif
        case (rx_q)
            RX_ARM: begin
                // Wait for one idle bit so a frame cut by reset is not mistaken for a start.
                if (!line_bit) rx_d = RX_IDLE;
            end
            RX_IDLE: begin
                if (line_bit) rx_d = RX_WBIT;
            end
            RX_WBIT: begin
                we_sr_d = line_bit;
                rcnt_d  = 6'd19;
                rx_d    = RX_ADDR;
            end
            RX_ADDR: begin
                adr_sr_d = {adr_sr_q[18:0], line_bit};
                rcnt_d   = rcnt_q - 6'd1;
                if (rcnt_q == 6'd0) begin
                    if (we_sr_q) begin
                        rcnt_d = 6'd31;
                        rx_d   = RX_DATA;
                    end else begin
`ifdef TURFBUS_PARITY_EN
                        rx_d = RX_PAR;
`else
                        rx_d       = RX_IDLE;
                        frame_done = 1'b1;
`endif
                    end
                end
            end
            RX_DATA: begin
                dat_sr_d = {dat_sr_q[30:0], line_bit};
                rcnt_d   = rcnt_q - 6'd1;
                if (rcnt_q == 6'd0) begin
`ifdef TURFBUS_PARITY_EN
                    rx_d = RX_PAR;
`else
                    rx_d       = RX_IDLE;
                    frame_done = 1'b1;
`endif
                end
            end
`ifdef TURFBUS_PARITY_EN
            RX_PAR: begin
                rx_d = RX_IDLE;
                if (par_calc == line_bit) frame_done = 1'b1;
                else                      frame_bad  = 1'b1;
            end
`endif
            default: rx_d = RX_ARM;
        endcase
    end

    // Receive FSM registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_q     <= RX_ARM;
            rcnt_q   <= 6'd0;
            we_sr_q  <= 1'b0;
            adr_sr_q <= 20'h0;
            dat_sr_q <= 32'h0;
        end else begin
            rx_q     <= rx_d;
            rcnt_q   <= rcnt_d;
            we_sr_q  <= we_sr_d;
            adr_sr_q <= adr_sr_d;
            dat_sr_q <= dat_sr_d;
        end
    end

    assign cmd_hs   = cmd_valid_q & cmd_ready_i;
    assign cmd_load = frame_done & (~cmd_valid_q | cmd_ready_i);

    // Holding register: load a completed frame if free (or freeing now), else drop it.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_we_d    = cmd_we_q;
        cmd_adr_d   = cmd_adr_q;
        cmd_dat_d   = cmd_dat_q;
        drop_d      = frame_done & ~cmd_load;
`ifdef TURFBUS_PARITY_EN
        perr_d      = frame_bad;
`endif
        if (cmd_hs) cmd_valid_d = 1'b0;
        if (cmd_load) begin
            cmd_valid_d = 1'b1;
            cmd_we_d    = we_sr_q;
            cmd_adr_d   = adr_sr_d;
            cmd_dat_d   = fr_dat;
        end
    end

    // Holding register and status pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_adr_q   <= 20'h0;
            cmd_dat_q   <= 32'h0;
            drop_q      <= 1'b0;
`ifdef TURFBUS_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_we_q    <= cmd_we_d;
            cmd_adr_q   <= cmd_adr_d;
            cmd_dat_q   <= cmd_dat_d;
            drop_q      <= drop_d;
`ifdef TURFBUS_PARITY_EN
            perr_q      <= perr_d;
`endif
        end
    end

    assign tidx = tcnt_q[4:0] - 5'd1;

    // Transmit FSM: sreq_d is the line level for the cycle after the edge.
    always_comb begin
        tx_d   = tx_q;
        tcnt_d = tcnt_q;
        tsr_d  = tsr_q;
        sreq_d = 1'b1;
        case (tx_q)
            TX_IDLE: begin
                if (rsp_valid_i) begin
                    tsr_d  = rsp_dat_i;
                    tx_d   = TX_START;
                    sreq_d = 1'b0;
                end
            end
            TX_START: begin
                tcnt_d = 6'd31;
                tx_d   = TX_SHIFT;
                sreq_d = ~tsr_q[31];
            end
            TX_SHIFT: begin
                if (tcnt_q == 6'd0) begin
`ifdef TURFBUS_PARITY_EN
                    tx_d   = TX_TPAR;
                    sreq_d = ~(^tsr_q);
`else
                    tx_d   = TX_IDLE;
`endif
                end else begin
                    tcnt_d = tcnt_q - 6'd1;
                    sreq_d = ~tsr_q[tidx];
                end
            end
`ifdef TURFBUS_PARITY_EN
            TX_TPAR: begin
                tx_d = TX_IDLE;
            end
`endif
            default: tx_d = TX_IDLE;
        endcase
    end

    // Transmit FSM registers and registered line driver.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_q   <= TX_IDLE;
            tcnt_q <= 6'd0;
            tsr_q  <= 32'h0;
            sreq_q <= 1'b1;
        end else begin
            tx_q   <= tx_d;
            tcnt_q <= tcnt_d;
            tsr_q  <= tsr_d;
            sreq_q <= sreq_d;
        end
    end

    assign sreq_neg_o  = sreq_q;
    assign rsp_ready_o = (tx_q == TX_IDLE);
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_we_o    = cmd_we_q;
    assign cmd_adr_o   = cmd_adr_q;
    assign cmd_dat_o   = cmd_dat_q;
    assign drop_o      = drop_q;
`ifdef TURFBUS_PARITY_EN
    assign perr_o      = perr_q;
`endif

endmodule

// File: tb/tb_turfbus_phy.sv
// tb_turfbus_phy: self-checking bench for turfbus_phy.
// Frames are queued as line bits; a frame-level reference model decides at
// each frame's last bit whether it is loaded, dropped or rejected, and a
// response model predicts the SREQ waveform from the accepted word.
module tb_turfbus_phy;

`ifdef TURFBUS_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int TXLEN = 33 + PAR;

    logic        clk;
    logic        rst_i;
    logic        treq_neg_i;
    logic        sreq_neg_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic        cmd_we_o;
    logic [19:0] cmd_adr_o;
    logic [31:0] cmd_dat_o;
    logic        rsp_valid_i;
    logic        rsp_ready_o;
    logic [31:0] rsp_dat_i;
    logic        drop_o;
`ifdef TURFBUS_PARITY_EN
    logic        perr_o;
`else
    logic        perr_o;
    assign perr_o = 1'b0;
`endif

    turfbus_phy dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .treq_neg_i  (treq_neg_i),
        .sreq_neg_o  (sreq_neg_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_we_o    (cmd_we_o),
        .cmd_adr_o   (cmd_adr_o),
        .cmd_dat_o   (cmd_dat_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_ready_o (rsp_ready_o),
        .rsp_dat_i   (rsp_dat_i),
`ifdef TURFBUS_PARITY_EN
        .perr_o      (perr_o),
`endif
        .drop_o      (drop_o)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        b;
        logic        last;
        logic        bad;
        logic        we;
        logic [19:0] adr;
        logic [31:0] dat;
    } lbit_t;

    lbit_t       line_q[$];
    logic [52:0] exp_q[$];

    int n_checks;
    int n_fail;
    int cycle;
    int rdy_mode;
    int rsp_mode;
    int hs_count;
    int drop_count;
    int perr_count;
    int valid_cycles;
    logic [52:0] last_hs;

    // Reference model state.
    logic        m_valid;
    logic        m_we;
    logic [19:0] m_adr;
    logic [31:0] m_dat;
    logic        m_drop;
    logic        m_perr;
    int          m_tx_k;
    logic [31:0] m_tx_dat;

    task automatic model_clear();
        m_valid  = 1'b0;
        m_we     = 1'b0;
        m_adr    = 20'h0;
        m_dat    = 32'h0;
        m_drop   = 1'b0;
        m_perr   = 1'b0;
        m_tx_k   = 0;
        m_tx_dat = 32'h0;
    endtask

    // Queue one frame as line bits, MSB first, marking the final bit.
    task automatic send_frame(input logic we, input logic [19:0] adr,
                              input logic [31:0] dat, input logic bad);
        logic [86:0] bits;
        int          n;
        lbit_t       e;
        bits = '0;
        n = 0;
        bits[n] = 1'b1; n++;
        bits[n] = we;   n++;
        for (int i = 19; i >= 0; i--) begin bits[n] = adr[i]; n++; end
        if (we) for (int i = 31; i >= 0; i--) begin bits[n] = dat[i]; n++; end
        if (PAR == 1) begin
            bits[n] = (^{we, adr, (we ? dat : 32'h0)}) ^ bad;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            e      = '0;
            e.b    = bits[i];
            e.last = (i == n - 1);
            e.bad  = bad;
            e.we   = we;
            e.adr  = adr;
            e.dat  = dat;
            line_q.push_back(e);
        end
    endtask

    task automatic send_gap(input int n);
        lbit_t e;
        e = '0;
        for (int i = 0; i < n; i++) line_q.push_back(e);
    endtask

    // One clock: drive inputs, advance, update the model, compare outputs.
    task automatic tick();
        lbit_t       e;
        logic        hs;
        logic [52:0] exp;
        logic        exp_line;
        e = '0;
        if (line_q.size() > 0) e = line_q.pop_front();
        treq_neg_i = ~e.b;
        case (rdy_mode)
            0:       cmd_ready_i = 1'b0;
            1:       cmd_ready_i = 1'b1;
            default: cmd_ready_i = 1'($urandom_range(0, 1));
        endcase
        if (rsp_mode == 2) begin
            rsp_valid_i = ($urandom_range(0, 5) == 0);
            rsp_dat_i   = $urandom;
        end
        // Scoreboard: a command handshake happens at this edge.
        if (cmd_valid_o === 1'b1 && cmd_ready_i === 1'b1) begin
            hs_count++;
            last_hs = {cmd_we_o, cmd_adr_o, cmd_dat_o};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL cmd_handshake: got %h expected no command", last_hs);
            end else begin
                exp = exp_q.pop_front();
                if (last_hs !== exp) begin
                    n_fail++;
                    $display("FAIL cmd_handshake: got %h expected %h", last_hs, exp);
                end
            end
        end
        @(posedge clk);
        cycle++;
        hs     = m_valid & cmd_ready_i;
        m_drop = 1'b0;
        m_perr = 1'b0;
        if (hs) m_valid = 1'b0;
        if (e.last) begin
            if (e.bad) m_perr = 1'b1;
            else if (!m_valid) begin
                m_valid = 1'b1;
                m_we    = e.we;
                m_adr   = e.adr;
                m_dat   = e.we ? e.dat : 32'h0;
                exp_q.push_back({m_we, m_adr, m_dat});
            end else m_drop = 1'b1;
        end
        if (m_tx_k == 0) begin
            if (rsp_valid_i) begin
                m_tx_k   = 1;
                m_tx_dat = rsp_dat_i;
            end
        end else if (m_tx_k >= TXLEN) m_tx_k = 0;
        else m_tx_k++;
        #1;
        if (m_tx_k == 0)       exp_line = 1'b1;
        else if (m_tx_k == 1)  exp_line = 1'b0;
        else if (m_tx_k <= 33) exp_line = ~m_tx_dat[33 - m_tx_k];
        else                   exp_line = ~(^m_tx_dat);
        n_checks++;
        if (cmd_valid_o !== m_valid) begin
            n_fail++;
            $display("FAIL cmd_valid cyc %0d: got %b expected %b", cycle, cmd_valid_o, m_valid);
        end
        if (m_valid) begin
            n_checks++;
            if ({cmd_we_o, cmd_adr_o, cmd_dat_o} !== {m_we, m_adr, m_dat}) begin
                n_fail++;
                $display("FAIL cmd_fields cyc %0d: got %h expected %h", cycle,
                         {cmd_we_o, cmd_adr_o, cmd_dat_o}, {m_we, m_adr, m_dat});
            end
        end
        n_checks++;
        if (drop_o !== m_drop) begin
            n_fail++;
            $display("FAIL drop cyc %0d: got %b expected %b", cycle, drop_o, m_drop);
        end
        n_checks++;
        if (perr_o !== m_perr) begin
            n_fail++;
            $display("FAIL perr cyc %0d: got %b expected %b", cycle, perr_o, m_perr);
        end
        n_checks++;
        if (sreq_neg_o !== exp_line) begin
            n_fail++;
            $display("FAIL sreq_line cyc %0d: got %b expected %b", cycle, sreq_neg_o, exp_line);
        end
        n_checks++;
        if (rsp_ready_o !== (m_tx_k == 0)) begin
            n_fail++;
            $display("FAIL rsp_ready cyc %0d: got %b expected %b", cycle, rsp_ready_o, (m_tx_k == 0));
        end
        if (drop_o === 1'b1) drop_count++;
        if (perr_o === 1'b1) perr_count++;
        if (cmd_valid_o === 1'b1) valid_cycles++;
    endtask

    task automatic drain(input int n);
        while (line_q.size() > 0) tick();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        treq_neg_i  = 1'b1;
        rsp_valid_i = 1'b0;
        rsp_dat_i   = 32'h0;
        cmd_ready_i = 1'b0;
        line_q.delete();
        exp_q.delete();
        model_clear();
        #2;
        n_checks++;
        if ({cmd_valid_o, cmd_we_o, cmd_adr_o, cmd_dat_o} !== 54'h0) begin
            n_fail++;
            $display("FAIL reset_cmd: got %h expected 0", {cmd_valid_o, cmd_we_o, cmd_adr_o, cmd_dat_o});
        end
        n_checks++;
        if (sreq_neg_o !== 1'b1 || rsp_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx: got sreq %b ready %b expected 1 1", sreq_neg_o, rsp_ready_o);
        end
        n_checks++;
        if (drop_o !== 1'b0 || perr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got drop %b perr %b expected 0 0", drop_o, perr_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_read();
        int start_cyc;
        bit seen;
        rdy_mode  = 0;
        start_cyc = cycle + 1;
        send_frame(1'b0, 20'h12345, 32'h0, 1'b0);
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            if (cmd_valid_o === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || (cycle - start_cyc) != 21 + PAR) begin
            n_fail++;
            $display("FAIL read_latency: got seen %0d after %0d edges expected %0d", seen, cycle - start_cyc, 21 + PAR);
        end
        n_checks++;
        if ({cmd_we_o, cmd_adr_o, cmd_dat_o} !== {1'b0, 20'h12345, 32'h0}) begin
            n_fail++;
            $display("FAIL read_fields: got %h expected %h", {cmd_we_o, cmd_adr_o, cmd_dat_o}, {1'b0, 20'h12345, 32'h0});
        end
        rdy_mode = 1;
        tick();
        tick();
        n_checks++;
        if (cmd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_release: got %b expected 0", cmd_valid_o);
        end
    endtask

    task automatic test_write();
        rdy_mode     = 1;
        hs_count     = 0;
        valid_cycles = 0;
        send_frame(1'b1, 20'hFFFFF, 32'hDEADBEEF, 1'b0);
        drain(5);
        n_checks++;
        if (valid_cycles != 1 || hs_count != 1) begin
            n_fail++;
            $display("FAIL write_single: got %0d valid %0d accepted expected 1 1", valid_cycles, hs_count);
        end
        n_checks++;
        if (last_hs !== {1'b1, 20'hFFFFF, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL write_fields: got %h expected %h", last_hs, {1'b1, 20'hFFFFF, 32'hDEADBEEF});
        end
    endtask

    task automatic test_back_to_back();
        rdy_mode   = 0;
        drop_count = 0;
        send_frame(1'b1, 20'hABCDE, 32'h12345678, 1'b0);
        send_frame(1'b0, 20'h55555, 32'h0, 1'b0);
        drain(5);
        n_checks++;
        if (drop_count != 1) begin
            n_fail++;
            $display("FAIL b2b_drop: got %0d expected 1", drop_count);
        end
        n_checks++;
        if ({cmd_valid_o, cmd_we_o, cmd_adr_o, cmd_dat_o} !== {1'b1, 1'b1, 20'hABCDE, 32'h12345678}) begin
            n_fail++;
            $display("FAIL b2b_held: got %h expected %h", {cmd_valid_o, cmd_we_o, cmd_adr_o, cmd_dat_o},
                     {1'b1, 1'b1, 20'hABCDE, 32'h12345678});
        end
        rdy_mode = 1;
        hs_count = 0;
        drain(3);
        n_checks++;
        if (hs_count != 1 || last_hs !== {1'b1, 20'hABCDE, 32'h12345678}) begin
            n_fail++;
            $display("FAIL b2b_accept: got %0d x %h expected 1 x %h", hs_count, last_hs, {1'b1, 20'hABCDE, 32'h12345678});
        end
    endtask

    task automatic test_response();
        int  lows;
        int  busy;
        bit  rdy;
        rsp_mode    = 0;
        rdy_mode    = 1;
        rsp_valid_i = 1'b0;
        rdy = 0;
        for (int i = 0; i < 100 && !rdy; i++) begin
            if (rsp_ready_o === 1'b1) rdy = 1;
            else tick();
        end
        n_checks++;
        if (!rdy) begin
            n_fail++;
            $display("FAIL rsp_wait_ready: got 0 expected 1");
        end
        rsp_valid_i = 1'b1;
        rsp_dat_i   = 32'h80000001;
        tick();
        rsp_valid_i = 1'b0;
        lows = (sreq_neg_o === 1'b0) ? 1 : 0;
        busy = (rsp_ready_o === 1'b0) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sreq_neg_o === 1'b0) lows++;
            if (rsp_ready_o === 1'b0) busy++;
        end
        n_checks++;
        if (lows != 3) begin
            n_fail++;
            $display("FAIL rsp_line_lows: got %0d expected 3", lows);
        end
        n_checks++;
        if (busy != TXLEN) begin
            n_fail++;
            $display("FAIL rsp_busy_cycles: got %0d expected %0d", busy, TXLEN);
        end
    endtask

    task automatic test_reset_mid();
        rdy_mode = 1;
        send_frame(1'b0, 20'hABCDE, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        test_reset();
        hs_count = 0;
        send_frame(1'b0, 20'h00001, 32'h0, 1'b0);
        drain(5);
        n_checks++;
        if (hs_count != 1 || last_hs !== {1'b0, 20'h00001, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_cmd: got %0d x %h expected 1 x %h", hs_count, last_hs, {1'b0, 20'h00001, 32'h0});
        end
    endtask

    task automatic test_random();
        rdy_mode = 2;
        rsp_mode = 2;
        for (int i = 0; i < 40; i++) begin
            send_frame(1'($urandom_range(0, 1)), 20'($urandom), $urandom, 1'b0);
            send_gap($urandom_range(0, 3));
        end
        drain(40);
        rsp_mode    = 0;
        rsp_valid_i = 1'b0;
        rdy_mode    = 1;
        drain(40);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_leftover: got %0d pending expected 0", exp_q.size());
        end
    endtask

`ifdef TURFBUS_PARITY_EN
    task automatic test_parity_error();
        rdy_mode     = 1;
        perr_count   = 0;
        drop_count   = 0;
        valid_cycles = 0;
        send_frame(1'b1, 20'h0F0F0, 32'hCAFEF00D, 1'b1);
        drain(5);
        n_checks++;
        if (perr_count != 1 || valid_cycles != 0 || drop_count != 0) begin
            n_fail++;
            $display("FAIL parity_error: got perr %0d valid %0d drop %0d expected 1 0 0",
                     perr_count, valid_cycles, drop_count);
        end
    endtask
`endif

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        cycle        = 0;
        rdy_mode     = 0;
        rsp_mode     = 0;
        hs_count     = 0;
        drop_count   = 0;
        perr_count   = 0;
        valid_cycles = 0;
        last_hs      = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_response();
        test_reset_mid();
        test_random();
`ifdef TURFBUS_PARITY_EN
        test_parity_error();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
